// File: rtl/sync_word_streamer.sv
// Snapshots a parallel sync word on start and streams it LSB-first as
// 32-bit AXI-Stream beats, tlast on the final beat, partial tstrb on a short tail.
module sync_word_streamer #(
    parameter int USED_CARRIERS             = 800,
    parameter int C_M_AXIS_SYNC_TDATA_WIDTH = 32
) (
    input  logic                                   m_axis_sync_aclk,
    input  logic                                   m_axis_sync_areset,
    input  logic [USED_CARRIERS-1:0]               sync_word,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   start_dropped,
    output logic                                   m_axis_sync_tvalid,
    input  logic                                   m_axis_sync_tready,
    output logic [C_M_AXIS_SYNC_TDATA_WIDTH-1:0]   m_axis_sync_tdata,
    output logic [C_M_AXIS_SYNC_TDATA_WIDTH/8-1:0] m_axis_sync_tstrb,
    output logic                                   m_axis_sync_tlast
);
    localparam int DW     = C_M_AXIS_SYNC_TDATA_WIDTH;
    localparam int SW     = DW / 8;
    localparam int NBEATS = (USED_CARRIERS + DW - 1) / DW;
    localparam int IW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int REM    = USED_CARRIERS % DW;
    localparam logic [SW-1:0] LAST_STRB = (REM == 0) ? {SW{1'b1}} : SW'((1 << (REM / 8)) - 1);
    localparam logic [10:0]   LAST_IDX  = 11'(NBEATS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                     state_q, state_d;
    logic [10:0]                cnt_q, cnt_d;
    logic [NBEATS-1:0][DW-1:0]  shadow_q, shadow_d;
    logic                       done_q, done_d;
    logic                       drop_q, drop_d;
    logic [NBEATS*DW-1:0]       sw_pad;
    logic                       last_beat;

    // Bits past USED_CARRIERS in the tail beat are forced to zero here.
    always_comb begin
        sw_pad = '0;
        sw_pad[USED_CARRIERS-1:0] = sync_word;
    end

    assign last_beat = (cnt_q == LAST_IDX);

    always_ff @(posedge m_axis_sync_aclk) begin
        if (m_axis_sync_areset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    // The shadow is only read while streaming, so it needs no reset.
    always_ff @(posedge m_axis_sync_aclk) begin
        shadow_q <= shadow_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = STREAM;
                    cnt_d    = '0;
                    shadow_d = sw_pad;
                end
            end
            STREAM: begin
                drop_d = start;
                if (m_axis_sync_tready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_axis_sync_tvalid = 1'b0;
        m_axis_sync_tdata  = '0;
        m_axis_sync_tstrb  = '0;
        m_axis_sync_tlast  = 1'b0;
        busy               = 1'b0;
        if (state_q == STREAM) begin
            m_axis_sync_tvalid = 1'b1;
            busy               = 1'b1;
            m_axis_sync_tdata  = shadow_q[cnt_q[IW-1:0]];
            m_axis_sync_tstrb  = last_beat ? LAST_STRB : {SW{1'b1}};
            m_axis_sync_tlast  = last_beat;
        end
        done          = done_q;
        start_dropped = drop_q;
    end
endmodule

// File: tb/tb_sync_word_streamer.sv
// Directed + randomized bench for sync_word_streamer: default 800-bit instance
// plus an 808-bit instance for the short-tail beat.
module tb_sync_word_streamer;
    localparam int NB  = 25;
    localparam int W8  = 808;
    localparam int NB8 = 26;

    logic        clk = 1'b0;
    logic        rst;
    logic [799:0] sync_word;
    logic        start, tready;
    logic        busy, done, dropped, tvalid, tlast;
    logic [31:0] tdata;
    logic [3:0]  tstrb;

    logic [W8-1:0] sync_word8;
    logic        start8;
    logic        busy8, done8, dropped8, tvalid8, tlast8;
    logic [31:0] tdata8;
    logic [3:0]  tstrb8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_word_streamer dut (
        .m_axis_sync_aclk(clk), .m_axis_sync_areset(rst), .sync_word(sync_word),
        .start(start), .busy(busy), .done(done), .start_dropped(dropped),
        .m_axis_sync_tvalid(tvalid), .m_axis_sync_tready(tready),
        .m_axis_sync_tdata(tdata), .m_axis_sync_tstrb(tstrb), .m_axis_sync_tlast(tlast)
    );

    sync_word_streamer #(.USED_CARRIERS(W8)) dut8 (
        .m_axis_sync_aclk(clk), .m_axis_sync_areset(rst), .sync_word(sync_word8),
        .start(start8), .busy(busy8), .done(done8), .start_dropped(dropped8),
        .m_axis_sync_tvalid(tvalid8), .m_axis_sync_tready(1'b1),
        .m_axis_sync_tdata(tdata8), .m_axis_sync_tstrb(tstrb8), .m_axis_sync_tlast(tlast8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_of(input logic [799:0] sw, input int k);
        return 32'(sw >> (32 * k));
    endfunction

    function automatic logic [799:0] rand_sw();
        logic [799:0] v;
        for (int i = 0; i < NB; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // One frame on the 800-bit instance. pre=1 means start was already
    // pulsed in the previous frame's done cycle. Negative *_at disables.
    task automatic frame(input logic [799:0] sw, input bit pre, input int pct,
                         input int drop_at, input int mut_at, input int rst_at,
                         input bit b2b, input logic [799:0] nsw);
        int k = 0;
        int cyc = 0;
        bit drop_pend = 0;
        bit nxt_drop = 0;
        bit dropped_once = 0;
        bit hs;
        if (!pre) begin
            sync_word = sw;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (1) begin
            chk("tvalid", 32'(tvalid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk($sformatf("tdata[%0d]", k), tdata, beat_of(sw, k));
            chk("tstrb", 32'(tstrb), 32'hF);
            chk("tlast", 32'(tlast), 32'(k == NB - 1));
            chk("start_dropped", 32'(dropped), 32'(drop_pend));
            chk("done_mid", 32'(done), 32'd0);
            if (k == rst_at) begin
                start = 1'b0;
                tready = 1'b1;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_tvalid", 32'(tvalid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_tlast", 32'(tlast), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_dropped", 32'(dropped), 32'd0);
                return;
            end
            start = 1'b0;
            nxt_drop = 1'b0;
            if (k == drop_at && !dropped_once) begin
                start = 1'b1;
                sync_word = ~sw;
                nxt_drop = 1'b1;
                dropped_once = 1'b1;
            end
            if (k == mut_at) sync_word = rand_sw();
            tready = ($urandom_range(99) < pct);
            hs = tready;
            @(negedge clk);
            cyc++;
            if (hs) begin
                if (k == NB - 1) break;
                k++;
            end
            drop_pend = nxt_drop;
            if (cyc > 2000) begin
                chk("frame_timeout", 32'(cyc), 32'd0);
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        chk("beats", 32'(k + 1), 32'(NB));
        chk("end_tvalid", 32'(tvalid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(done), 32'd1);
        chk("end_dropped", 32'(dropped), 32'(nxt_drop));
        tready = 1'($urandom_range(1));
        if (b2b) begin
            sync_word = nsw;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd0);
        if (!b2b) chk("idle_tvalid", 32'(tvalid), 32'd0);
    endtask

    initial begin
        logic [799:0] sw_a, sw_b, sw_c, sw_d;
        logic [W8-1:0] sw8;
        int k8;

        rst = 1'b1; start = 1'b0; start8 = 1'b0; tready = 1'b0;
        sync_word = '0; sync_word8 = '0;
        repeat (2) @(negedge clk);
        chk("reset_tvalid", 32'(tvalid), 32'd0);
        chk("reset_tlast", 32'(tlast), 32'd0);
        chk("reset_tdata", tdata, 32'd0);
        chk("reset_tstrb", 32'(tstrb), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dropped", 32'(dropped), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Alternating pattern, bit i = i mod 2, always ready.
        for (int i = 0; i < 800; i++) sw_a[i] = 1'(i % 2);
        frame(sw_a, 0, 100, -1, -1, -1, 0, '0);

        // Marker words at both ends, ~50% ready, sync_word changed mid-frame.
        sw_b = '0;
        sw_b[31:0] = 32'hDEADBEEF;
        sw_b[799:768] = 32'h12345678;
        frame(sw_b, 0, 50, -1, 5, -1, 0, '0);

        // Start during beat 10 is dropped; start in the done cycle chains a frame.
        sw_c = rand_sw();
        sw_d = rand_sw();
        frame(sw_c, 0, 100, 10, -1, -1, 1, sw_d);
        frame(sw_d, 1, 70, -1, -1, -1, 0, '0);

        // Reset at beat 12, then a full frame afterwards.
        frame(rand_sw(), 0, 100, -1, -1, 12, 0, '0);
        @(negedge clk);
        frame(rand_sw(), 0, 100, -1, -1, -1, 0, '0);

        for (int r = 0; r < 4; r++)
            frame(rand_sw(), 0, 30 + 20 * r, -1, 3 + r, -1, 0, '0);

        // 808-bit instance, all ones: short tail beat.
        sw8 = '1;
        sync_word8 = sw8;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        k8 = 0;
        while (k8 < NB8) begin
            chk("w8_tvalid", 32'(tvalid8), 32'd1);
            chk($sformatf("w8_tdata[%0d]", k8), tdata8, 32'(sw8 >> (32 * k8)));
            chk("w8_tstrb", 32'(tstrb8),
                (k8 == NB8 - 1) ? 32'((1 << ((W8 % 32) / 8)) - 1) : 32'hF);
            chk("w8_tlast", 32'(tlast8), 32'(k8 == NB8 - 1));
            @(negedge clk);
            k8++;
        end
        chk("w8_end_tvalid", 32'(tvalid8), 32'd0);
        chk("w8_end_done", 32'(done8), 32'd1);
        chk("w8_end_busy", 32'(busy8), 32'd0);
        chk("w8_dropped", 32'(dropped8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sync_word_streamer.md
# sync_word_streamer

Transmit-side counterpart of the sync-word loader. The loader assembles the OFDM sync word from a 32-bit AXI-Stream config interface. This block takes a parallel `USED_CARRIERS`-bit sync word and, on a start pulse, snapshots it and emits it LSB-first as 32-bit AXI-Stream beats with `tlast` on the final beat. It sits between the framer's sync-word register and any downstream consumer: a readback DMA, or a second framer instance loaded over its config stream.

## Interface
- `USED_CARRIERS`, 800, width of `sync_word` in bits; multiple of 8, range 8..2047.
- `C_M_AXIS_SYNC_TDATA_WIDTH`, 32, stream data width; fixed at 32.
- `m_axis_sync_aclk`  input  1  sole clock; all logic is on the rising edge.
- `m_axis_sync_areset`  input  1  reset; synchronous, active-high.
- `sync_word`  input  USED_CARRIERS  parallel sync word; sampled only on an accepted start.
- `start`  input  1  single-cycle request to stream one frame.
- `busy`  output  1  high from the cycle after an accepted start until the last beat handshakes.
- `done`  output  1  one-cycle pulse, the cycle after the last-beat handshake.
- `start_dropped`  output  1  one-cycle pulse when `start` arrives while `busy`.
- `m_axis_sync_tvalid`  output  1  beat valid.
- `m_axis_sync_tready`  input  1  downstream ready.
- `m_axis_sync_tdata`  output  32  beat data.
- `m_axis_sync_tstrb`  output  4  byte qualifiers; all ones except possibly on the last beat.
- `m_axis_sync_tlast`  output  1  high on the final beat only.

## Operation
- `NBEATS` = ceil(`USED_CARRIERS`/32); for 800 this is 25. Beat counter is 11 bits.
- FSM has two states.
  - IDLE: `start`=1 latches `sync_word` into an internal shadow register, clears the beat counter and moves to STREAM.
  - STREAM: drives beat k, where `tdata` = shadow[32k +: 32]. Bits at index ≥ `USED_CARRIERS` are driven 0.
  - On `tvalid && tready` in STREAM: if k = `NBEATS`-1, go to IDLE; otherwise k increments.
- Last-beat `tstrb` = (1 << ((`USED_CARRIERS` mod 32)/8)) - 1. When the remainder is 0, it is 4'b1111.
- Changes to `sync_word` after the start is accepted have no effect on the frame in flight.
- `start` while in STREAM is ignored: `start_dropped` pulses the next cycle and the shadow register is unchanged.
- `start` in the same cycle as `done` (IDLE) is accepted normally, giving back-to-back frames.
- Reset mid-frame:
  - The next cycle has `tvalid`=0, `tlast`=0, `busy`=0, `done`=0, `start_dropped`=0, state IDLE, counter 0.
  - The partial frame is abandoned without `tlast`.

## Timing
- Reset values: `tvalid`=0, `tlast`=0, `tdata`=0, `tstrb`=0, `busy`=0, `done`=0, `start_dropped`=0.
- Start latency: `start` accepted at cycle T gives `tvalid`=1 with beat 0 and `busy`=1 at T+1.
- AXI-Stream rules:
  - Once `tvalid`=1, `tdata`, `tstrb` and `tlast` hold stable until the handshake.
  - `tvalid` never drops mid-frame.
  - `tvalid` does not depend combinationally on `tready`.
- Throughput: with `tready` held at 1, one beat per cycle. A frame occupies `NBEATS` consecutive cycles, T+1..T+`NBEATS`.
- End of frame: last handshake at cycle L gives, at L+1, `tvalid`=0, `busy`=0 and `done`=1 for exactly one cycle.
- Back-to-back: `start` at L+1 gives the next beat 0 at L+2, so there is one idle cycle between frames.
- `tready` is a don't-care while `tvalid`=0.

## Test plan
- Default parameter, `sync_word` = pattern with bit i = i mod 2, `tready`=1, pulse `start`:
  - 25 beats on consecutive cycles, each `tdata`=32'hAAAAAAAA, `tstrb`=4'hF.
  - `tlast` only on beat 24; `done` the cycle after.
- Default parameter, `sync_word` = bits [31:0]=32'hDEADBEEF and bits [799:768]=32'h12345678, other bits 0. `tready` toggles pseudo-randomly (~50%):
  - Beat 0 = 32'hDEADBEEF, beat 24 = 32'h12345678.
  - Data is held stable during every stall.
  - Beat count is 25; `sync_word` changes mid-frame do not appear on the stream.
- `USED_CARRIERS`=808, `sync_word` all ones:
  - 26 beats; beat 25 has `tdata`=32'h000000FF, `tstrb`=4'b0001, `tlast`=1.
- `start` pulsed at beat 10 of a frame:
  - `start_dropped` pulses once; the frame completes with 25 beats and the original data.
  - A `start` in the `done` cycle yields a new frame beat 0 exactly two cycles after the last handshake.
- Assert `m_axis_sync_areset` for one cycle at beat 12:
  - Next cycle `tvalid`=0, `busy`=0, no `tlast`, no `done`.
  - A subsequent `start` produces a complete 25-beat frame starting from beat 0.
